// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants: MAC-derived widths and output quantisation bounds.
// Optional build macro PSUM_RELU_EN (consumed by quant_round_sat) clamps negatives to 0.
package cnn_pkg;

   // MAC tree geometry the partial-sum width is derived from
   localparam int CNN_MAC_LANES = 16;
   localparam int CNN_MAC_WIN   = 8;

   // Two 8-bit operands per product, log2(lanes) tree growth, 2 guard bits
   localparam int CNN_WA   = 2 * CNN_MAC_WIN + $clog2(CNN_MAC_LANES) + 2;
   localparam int CNN_WACC = 32;
   localparam int CNN_WB   = 16;
   localparam int CNN_WQ   = 8;
   localparam int CNN_WCNT = 9;

   // Signed output range
   localparam int CNN_QMAX = (2 ** (CNN_WQ - 1)) - 1;
   localparam int CNN_QMIN = -(2 ** (CNN_WQ - 1));

endpackage

// File: rtl/quant_round_sat.sv
// Requantisation datapath: registered round-half-up arithmetic shift (P2) followed by
// combinational saturation (P3) to the signed output range.
// Build macro PSUM_RELU_EN: lower clamp bound becomes 0 (negatives -> 0).
module quant_round_sat
   import cnn_pkg::*;
#(
   parameter int unsigned WIN = CNN_WACC + 1,
   parameter int unsigned WQ  = CNN_WQ,
   parameter int          QHI = CNN_QMAX,
   parameter int          QLO = CNN_QMIN
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clr_i,
   input  logic                  vld_i,
   input  logic signed [WIN-1:0] s1_i,
   input  logic        [4:0]     shift_i,
   output logic                  vld_o,
   output logic        [WQ-1:0]  q_o
);

   // One extra bit so adding the rounding constant can never overflow
   localparam int unsigned WS = WIN + 1;

`ifdef PSUM_RELU_EN
   localparam int LO_I = 0;
`else
   localparam int LO_I = QLO;
`endif

   localparam logic signed [WS-1:0] HI = WS'(QHI);
   localparam logic signed [WS-1:0] LO = WS'(LO_I);

   logic signed [WS-1:0] s1_ext;
   logic        [WS-1:0] one_sh;
   logic signed [WS-1:0] rnd;
   logic signed [WS-1:0] s2_d;
   logic signed [WS-1:0] s2_q;
   logic                 s2_vld_q;

   // Round half toward +inf: add 2^(shift-1) (zero when shift==0), then arithmetic shift
   always_comb begin
      s1_ext = {s1_i[WIN-1], s1_i};
      one_sh = {{(WS-1){1'b0}}, 1'b1} << shift_i;
      rnd    = $signed(one_sh >> 1);
      s2_d   = (s1_ext + rnd) >>> shift_i;
   end

   // P2 register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_q     <= '0;
         s2_vld_q <= 1'b0;
      end else if (clr_i) begin
         s2_q     <= '0;
         s2_vld_q <= 1'b0;
      end else begin
         s2_vld_q <= vld_i;
         if (vld_i) begin
            s2_q <= s2_d;
         end
      end
   end

   // P3 saturation into the output range
   always_comb begin
      if (s2_q > HI) begin
         q_o = WQ'(QHI);
      end else if (s2_q < LO) begin
         q_o = WQ'(LO_I);
      end else begin
         q_o = s2_q[WQ-1:0];
      end
   end

   assign vld_o = s2_vld_q;

endmodule

// File: rtl/psum_requant.sv
// Partial-sum requantiser: accumulates cfg_nacc MAC partial sums, adds bias, rounds,
// shifts and saturates, then queues results in a 2-entry first-word-fall-through FIFO.
// The input side never stalls; a result arriving at a full FIFO is dropped (ovf_o).
// Build macro PSUM_RELU_EN: output clamps negatives to 0.
module psum_requant
   import cnn_pkg::*;
#(
   parameter int unsigned WA   = CNN_WA,
   parameter int unsigned WACC = CNN_WACC,
   parameter int unsigned WB   = CNN_WB,
   parameter int unsigned WQ   = CNN_WQ,
   parameter int unsigned WCNT = CNN_WCNT
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   clr_i,
   input  logic        [WCNT-1:0] cfg_nacc,
   input  logic        [4:0]      cfg_shift,
   input  logic signed [WB-1:0]   bias_i,
   input  logic                   vld_i,
   input  logic signed [WA-1:0]   acc_i,
   output logic        [WQ-1:0]   q_o,
   output logic                   q_vld_o,
   input  logic                   q_rdy_i,
   output logic                   busy_o,
   output logic                   ovf_o
);

   // Stage A state
   logic        [WCNT-1:0] cnt_q, cnt_d, cnt_base, last_idx;
   logic signed [WACC-1:0] acc_q, acc_d, acc_sum;
   logic                   last;

   // Stage A -> P1 registers
   logic                   pa_vld_q;
   logic signed [WACC-1:0] pa_acc_q;
   logic signed [WB-1:0]   pa_bias_q;
   logic        [4:0]      pa_shift_q;

   // P1 registers
   logic                   s1_vld_q;
   logic signed [WACC:0]   s1_q;
   logic        [4:0]      s1_shift_q;

   // P2/P3 outputs
   logic                   p3_vld;
   logic        [WQ-1:0]   p3_q;

   // FIFO
   logic        [WQ-1:0]   mem_q [2];
   logic        [1:0]      wptr_q, rptr_q, fill;
   logic                   fifo_empty, fifo_full, pop, do_push, drop;

   // Group counter / accumulator next state; clr_i makes this beat start a new group
   always_comb begin
      cnt_base = clr_i ? '0 : cnt_q;
      last_idx = (cfg_nacc == '0) ? '0 : cfg_nacc - WCNT'(1);
      last     = (cnt_base >= last_idx);
      acc_sum  = ((cnt_base == '0) ? '0 : acc_q) + {{(WACC-WA){acc_i[WA-1]}}, acc_i};
      cnt_d    = cnt_base;
      acc_d    = clr_i ? '0 : acc_q;
      if (vld_i) begin
         acc_d = acc_sum;
         cnt_d = last ? '0 : cnt_base + WCNT'(1);
      end
   end

   // Stage A registers and hand-off of the closed group to P1
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         pa_vld_q   <= 1'b0;
         pa_acc_q   <= '0;
         pa_bias_q  <= '0;
         pa_shift_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         pa_vld_q <= vld_i & last;
         if (vld_i & last) begin
            pa_acc_q   <= acc_sum;
            pa_bias_q  <= bias_i;
            pa_shift_q <= cfg_shift;
         end
      end
   end

   // P1: add sign-extended bias at WACC+1 bits
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_vld_q   <= 1'b0;
         s1_q       <= '0;
         s1_shift_q <= '0;
      end else if (clr_i) begin
         s1_vld_q   <= 1'b0;
      end else begin
         s1_vld_q <= pa_vld_q;
         if (pa_vld_q) begin
            s1_q       <= {pa_acc_q[WACC-1], pa_acc_q}
                          + {{(WACC+1-WB){pa_bias_q[WB-1]}}, pa_bias_q};
            s1_shift_q <= pa_shift_q;
         end
      end
   end

   quant_round_sat #(
      .WIN (WACC + 1),
      .WQ  (WQ),
      .QHI ((2 ** (int'(WQ) - 1)) - 1),
      .QLO (-(2 ** (int'(WQ) - 1)))
   ) u_qrs (
      .clk     (clk),
      .rstn    (rstn),
      .clr_i   (clr_i),
      .vld_i   (s1_vld_q),
      .s1_i    (s1_q),
      .shift_i (s1_shift_q),
      .vld_o   (p3_vld),
      .q_o     (p3_q)
   );

   // FIFO status and handshake; a full FIFO still accepts a push when it pops that cycle
   always_comb begin
      fill       = wptr_q - rptr_q;
      fifo_empty = (fill == 2'd0);
      fifo_full  = (fill == 2'd2);
      pop        = ~fifo_empty & q_rdy_i;
      do_push    = p3_vld & (~fifo_full | pop);
      drop       = p3_vld & fifo_full & ~pop;
   end

   // FIFO storage, pointers and sticky overflow flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         ovf_o    <= 1'b0;
      end else if (clr_i) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         ovf_o    <= 1'b0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q[0]] <= p3_q;
            wptr_q           <= wptr_q + 2'd1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 2'd1;
         end
         if (drop) begin
            ovf_o <= 1'b1;
         end
      end
   end

   // Outputs
   always_comb begin
      q_vld_o = ~fifo_empty;
      q_o     = fifo_empty ? '0 : mem_q[rptr_q[0]];
      busy_o  = (cnt_q != '0) | pa_vld_q | s1_vld_q | p3_vld | ~fifo_empty;
   end

endmodule
